// File: rtl/ssp_uart_ptx.sv
// FIFO-buffered UART transmit engine with optional 2-stop, parity and RS-485 DE tail hold.
// Parity support is compiled in only when SSP_UART_PTX_PARITY_EN is defined.
module ssp_uart_ptx #(
   parameter int unsigned DATA_W     = 8,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned BAUD_DIV_W = 16
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic [BAUD_DIV_W-1:0]         Baud_Div,
   input  logic                          Par_En,
   input  logic                          Par_Odd,
   input  logic                          Stop2,
   input  logic                          Mode485,
   input  logic                          Wr_En,
   input  logic [DATA_W-1:0]             Wr_Data,
   input  logic                          Ovf_Clr,
   input  logic                          xCTS,
   output logic                          TxD,
   output logic                          xDE,
   output logic                          Full,
   output logic                          Empty,
   output logic [$clog2(FIFO_DEPTH):0]   Count,
   output logic                          Ovf,
   output logic                          TxIdle
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned BW = $clog2(DATA_W);

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StStart  = 3'd1,
      StData   = 3'd2,
`ifdef SSP_UART_PTX_PARITY_EN
      StParity = 3'd3,
`endif
      StStop   = 3'd4,
      StTail   = 3'd5
   } state_e;

   state_e                state_q, state_d;
   logic [BAUD_DIV_W-1:0] baud_q, baud_d;
   logic [BAUD_DIV_W-1:0] div_q, div_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic                  stop_q, stop_d;
   logic                  stop2_q, stop2_d;
   logic                  mode_q, mode_d;
   logic [DATA_W-1:0]     shift_q, shift_d;
`ifdef SSP_UART_PTX_PARITY_EN
   logic                  par_en_q, par_en_d;
   logic                  par_q, par_d;
`else
   logic                  unused_par;
   assign unused_par = Par_En ^ Par_Odd;
`endif

   logic [DATA_W-1:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic                  full_q, full_d;
   logic                  empty_q, empty_d;
   logic                  ovf_q, ovf_d;
   logic                  txd_q, txd_d;
   logic                  xde_q, xde_d;
   logic                  idle_q, idle_d;

   logic                  push, pop, load_start, start_ok, bit_end;

   assign start_ok = Mode485 | ~xCTS;
   assign bit_end  = (baud_q == '0);
   // A full FIFO drops the write even if a pop frees a slot this cycle.
   assign push     = Wr_En & ~full_q;

   always_comb begin
      state_d    = state_q;
      baud_d     = baud_q;
      div_d      = div_q;
      bit_d      = bit_q;
      stop_d     = stop_q;
      stop2_d    = stop2_q;
      mode_d     = mode_q;
      shift_d    = shift_q;
`ifdef SSP_UART_PTX_PARITY_EN
      par_en_d   = par_en_q;
      par_d      = par_q;
`endif
      load_start = 1'b0;
      if (state_q != StIdle && !bit_end) baud_d = baud_q - 1'b1;
      unique case (state_q)
         StIdle: begin
            if (!empty_q && start_ok) load_start = 1'b1;
         end
         StStart: begin
            if (bit_end) begin
               state_d = StData;
               bit_d   = '0;
               baud_d  = div_q;
            end
         end
         StData: begin
            if (bit_end) begin
               baud_d  = div_q;
               shift_d = shift_q >> 1;
               if (bit_q == BW'(DATA_W - 1)) begin
                  stop_d  = 1'b0;
`ifdef SSP_UART_PTX_PARITY_EN
                  state_d = par_en_q ? StParity : StStop;
`else
                  state_d = StStop;
`endif
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
`ifdef SSP_UART_PTX_PARITY_EN
         StParity: begin
            if (bit_end) begin
               state_d = StStop;
               stop_d  = 1'b0;
               baud_d  = div_q;
            end
         end
`endif
         StStop: begin
            if (bit_end) begin
               if (stop2_q && !stop_q) begin
                  stop_d = 1'b1;
                  baud_d = div_q;
               end else if (!empty_q && start_ok) begin
                  load_start = 1'b1;
               end else if (mode_q) begin
                  state_d = StTail;
                  baud_d  = div_q;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StTail: begin
            if (bit_end) begin
               if (!empty_q && start_ok) load_start = 1'b1;
               else                      state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // Every frame start pops the head entry and latches the frame format.
      if (load_start) begin
         state_d  = StStart;
         baud_d   = Baud_Div;
         div_d    = Baud_Div;
         stop2_d  = Stop2;
         mode_d   = Mode485;
         shift_d  = mem[rd_ptr_q];
`ifdef SSP_UART_PTX_PARITY_EN
         par_en_d = Par_En;
         par_d    = (^mem[rd_ptr_q]) ^ Par_Odd;
`endif
      end
   end

   assign pop = load_start;

   always_comb begin
      wr_ptr_d = wr_ptr_q + AW'(push);
      rd_ptr_d = rd_ptr_q + AW'(pop);
      count_d  = count_q + CW'(push) - CW'(pop);
      full_d   = (count_d == CW'(FIFO_DEPTH));
      empty_d  = (count_d == '0);
      ovf_d    = (Wr_En & full_q) | (ovf_q & ~Ovf_Clr);
      idle_d   = (state_d == StIdle) && (count_d == '0);
      xde_d    = mode_q && (state_q != StIdle);
      unique case (state_q)
         StStart:  txd_d = 1'b0;
         StData:   txd_d = shift_q[0];
`ifdef SSP_UART_PTX_PARITY_EN
         StParity: txd_d = par_q;
`endif
         default:  txd_d = 1'b1;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (push) mem[wr_ptr_q] <= Wr_Data;
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q  <= StIdle;
         baud_q   <= '0;
         div_q    <= '0;
         bit_q    <= '0;
         stop_q   <= 1'b0;
         stop2_q  <= 1'b0;
         mode_q   <= 1'b0;
         shift_q  <= '0;
`ifdef SSP_UART_PTX_PARITY_EN
         par_en_q <= 1'b0;
         par_q    <= 1'b0;
`endif
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
         empty_q  <= 1'b1;
         ovf_q    <= 1'b0;
         txd_q    <= 1'b1;
         xde_q    <= 1'b0;
         idle_q   <= 1'b1;
      end else begin
         state_q  <= state_d;
         baud_q   <= baud_d;
         div_q    <= div_d;
         bit_q    <= bit_d;
         stop_q   <= stop_d;
         stop2_q  <= stop2_d;
         mode_q   <= mode_d;
         shift_q  <= shift_d;
`ifdef SSP_UART_PTX_PARITY_EN
         par_en_q <= par_en_d;
         par_q    <= par_d;
`endif
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         full_q   <= full_d;
         empty_q  <= empty_d;
         ovf_q    <= ovf_d;
         txd_q    <= txd_d;
         xde_q    <= xde_d;
         idle_q   <= idle_d;
      end
   end

   assign TxD    = txd_q;
   assign xDE    = xde_q;
   assign Full   = full_q;
   assign Empty  = empty_q;
   assign Count  = count_q;
   assign Ovf    = ovf_q;
   assign TxIdle = idle_q;

endmodule

// File: doc/ssp_uart_ptx.md
# ssp_uart_ptx

Parametrised, FIFO-buffered UART transmit engine. It is the next-generation transmit path for the SSP UART family. It generalises character width and FIFO depth, and adds 2-stop-bit framing, odd/even parity, a sticky overflow flag and RS-485 driver-enable tail hold. It sits between the SSP register write port and the RS-232/RS-485 line pins.

## Interface
- DATA_W, 8, character width in bits; legal range 5..9.
- FIFO_DEPTH, 16, transmit FIFO entries; power of 2, minimum 2.
- BAUD_DIV_W, 16, width of the bit-rate divisor.
- Clk  in  1  system clock; all logic is on the rising edge.
- Rst  in  1  asynchronous, active-low reset.
- Baud_Div  in  BAUD_DIV_W  bit period is Baud_Div+1 Clk cycles.
- Par_En  in  1  append a parity bit.
- Par_Odd  in  1  1 = odd parity, 0 = even parity.
- Stop2  in  1  1 = two stop bits, 0 = one stop bit.
- Mode485  in  1  1 = RS-485 mode (uses xDE, ignores xCTS), 0 = RS-232 mode.
- Wr_En  in  1  push Wr_Data into the FIFO.
- Wr_Data  in  DATA_W  character to transmit.
- Ovf_Clr  in  1  clear the Ovf flag.
- xCTS  in  1  RS-232 clear-to-send, active-low.
- TxD  out  1  serial data, registered.
- xDE  out  1  RS-485 driver enable, active-high, registered.
- Full  out  1  FIFO full.
- Empty  out  1  FIFO empty.
- Count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- Ovf  out  1  sticky flag: a write was dropped.
- TxIdle  out  1  FSM in IDLE with the FIFO empty.

## Operation
- Reset values: TxD=1, xDE=0, Full=0, Empty=1, Count=0, Ovf=0, TxIdle=1. The FIFO pointers, baud counter and FSM are all cleared.
- FIFO behaviour:
  - Synchronous write when Wr_En=1 and Full=0.
  - Wr_En=1 with Full=1 drops the data and sets Ovf. This holds even if a pop occurs in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
  - A simultaneous write and pop leaves Count unchanged.
- Ovf clearing: Ovf_Clr clears Ovf. If a set and a clear occur in the same cycle, the set wins.
- Frame start: Baud_Div, Par_En, Par_Odd, Stop2 and Mode485 are latched when the FSM leaves IDLE. Later changes to these inputs affect only the next frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, TAIL.
  - IDLE→START: the FIFO is non-empty and either (Mode485=0 and xCTS=0) or Mode485=1. The head entry is popped into the shift register on this transition.
  - START→DATA after 1 bit period.
  - DATA: sends DATA_W bits, LSB first, one per bit period. Then goes to PARITY if Par_En=1, else to STOP.
  - PARITY: sends the XOR of the data bits (inverted when Par_Odd=1) for 1 bit period, then goes to STOP.
  - STOP: TxD=1 for 1 or 2 bit periods. Then:
    - FIFO non-empty and start condition met → START directly (back-to-back frames, no idle gap).
    - Mode485=1 otherwise → TAIL.
    - Otherwise → IDLE.
  - TAIL: xDE stays high for 1 bit period, TxD=1, then goes to IDLE. A write arriving during TAIL goes to START at the end of the TAIL period.
- xCTS handling: sampled only in IDLE and at the end of STOP. Deasserting xCTS mid-frame never truncates the frame.
- xDE: high from START through STOP/TAIL whenever the latched Mode485=1; otherwise 0. It stays high continuously across back-to-back frames.
- Reset mid-frame: TxD returns to 1 and xDE to 0 immediately (asynchronously). FIFO contents are discarded.

## Timing
- Write-to-line latency: Wr_En sampled at edge k with the FSM idle and start condition met. Count=1 after edge k. FSM enters START at edge k+1. TxD falls at edge k+2.
- Each bit, including the start bit, lasts exactly Baud_Div+1 cycles. Baud_Div=0 gives one bit per clock.
- The baud counter reloads on every state entry. There is no fractional drift.
- Frame length in bit periods = 1 + DATA_W + Par_En + (Stop2 ? 2 : 1), plus 1 for TAIL in RS-485 mode.
- Full, Empty and Count are registered and update on the edge after the write or pop.
- TxIdle goes high on the edge the FSM returns to IDLE with Count=0.

## Configuration
- SSP_UART_PTX_PARITY_EN:
  - Defined: the PARITY state and parity logic are compiled in.
  - Undefined: the PARITY state is absent, Par_En and Par_Odd are ignored, and frames never carry a parity bit.

## Test plan
- DATA_W=8, Baud_Div=3, Mode485=0, xCTS=0, write 0xA5 → TxD low 4 cycles starting at edge k+2, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high 4 cycles; TxIdle=1 afterwards.
- SSP_UART_PTX_PARITY_EN defined, Par_En=1, Par_Odd=1, Stop2=1, write 0x03 → parity bit 1, then two stop bits; total 12 bit periods.
- FIFO_DEPTH=4, xCTS=1, 5 writes 0x10..0x14 → Full=1 and Count=4 after the 4th write; Ovf=1 after the 5th; TxD stays 1. Release xCTS → 0x10..0x13 sent back-to-back with no gap. Ovf_Clr → Ovf=0.
- Mode485=1, xCTS=1, write two characters → xDE rises with the start bit, stays high across both frames, falls 1 bit period after the last stop bit.
- Deassert xCTS midway through a frame → the current frame completes; the next queued character waits in IDLE until xCTS=0.
- Assert Rst mid-DATA → TxD=1, xDE=0, Count=0 and Empty=1 immediately; after release, a new write is transmitted normally.
